// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder/subtractor.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int n, input int w);
        return n / w;
    endfunction

    // Chunk counter width; a single-chunk build still needs one bit.
    function automatic int calc_cnt_w(input int n, input int w);
        int nc;
        nc = n / w;
        return (nc > 1) ? $clog2(nc) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_ripple_chunk.sv
// W-bit combinational ripple-carry slice built from full-adder cells.
module ripple_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[W];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle N-bit adder/subtractor, W bits per clock, LSB chunk first.
// Optional signed-overflow output is enabled by defining SEQ_CHUNK_ADDER_OVF_EN.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for operands (once out of reset)
//   BUSY  | one chunk per clock through the ripple slice
//   DONE  | result valid, held until the consumer takes it
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         busy
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int NCHUNK = calc_nchunk(N, W);
    localparam int CNT_W  = calc_cnt_w(N, W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    state_t state_q, state_d;

    logic             armed_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic             carry_q;
    logic [CNT_W-1:0] k_q;
    logic [N-1:0]     sum_q;
    logic             cout_q;

    logic [W-1:0]     sl_a;
    logic [W-1:0]     sl_b;
    logic [W-1:0]     sl_s;
    logic             sl_co;
    logic             accept;
    logic             last_chunk;

    assign accept     = in_valid && in_ready;
    assign last_chunk = (k_q == LAST);
    assign sl_a       = a_q[k_q*W +: W];
    assign sl_b       = b_q[k_q*W +: W];

    ripple_chunk #(.W(W)) u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry_q),
        .s  (sl_s),
        .co (sl_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last_chunk) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready stays low through reset and rises on the first clock after it.
    always_comb begin
        in_ready  = armed_q && (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (accept) begin
                a_q     <= a;
                b_q     <= sub ? ~b : b;
                carry_q <= sub | cin;
                k_q     <= '0;
            end else if (state_q == BUSY) begin
                sum_q[k_q*W +: W] <= sl_s;
                carry_q           <= sl_co;
                k_q               <= last_chunk ? '0 : k_q + CNT_W'(1);
                if (last_chunk) begin
                    cout_q <= sl_co;
                end
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic ovf_q;

    // Top chunk carries the sign bits, so overflow is resolved on the last slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == BUSY && last_chunk) begin
            ovf_q <= (a_q[N-1] == b_q[N-1]) && (sl_s[W-1] != a_q[N-1]);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: a 32/8 instance and an 8/8 instance.
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        w_in_valid = 1'b0, w_in_ready, w_cin = 1'b0, w_sub = 1'b0;
    logic        w_out_valid, w_out_ready = 1'b0, w_cout, w_busy;
    logic [31:0] w_a = '0, w_b = '0, w_sum;
    logic        n_in_valid = 1'b0, n_in_ready, n_cin = 1'b0, n_sub = 1'b0;
    logic        n_out_valid, n_out_ready = 1'b0, n_cout, n_busy;
    logic [7:0]  n_a = '0, n_b = '0, n_sum;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic        w_ovf, n_ovf;
`endif

    seq_chunk_adder #(.N(32), .W(8)) u_wide (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .sum(w_sum), .cout(w_cout), .busy(w_busy)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        , .ovf(w_ovf)
`endif
    );

    seq_chunk_adder #(.N(8), .W(8)) u_narrow (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .cin(n_cin), .sub(n_sub), .out_valid(n_out_valid),
        .out_ready(n_out_ready), .sum(n_sum), .cout(n_cout), .busy(n_busy)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        , .ovf(n_ovf)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain arithmetic: bits [n-1:0] are the result, bit n is the carry out.
    function automatic logic [32:0] model(input int n, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [32:0] mask, bb;
        mask = (33'd1 << n) - 33'd1;
        bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        return ({1'b0, a} & mask) + bb + (sub ? 33'd1 : {32'd0, cin});
    endfunction

    function automatic logic model_ovf(input int n, input logic [31:0] a, input logic [31:0] b,
                                       input logic sub, input logic [31:0] s);
        logic sa, sb, ss;
        sa = a[n-1];
        sb = b[n-1];
        ss = s[n-1];
        return sub ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
    endfunction

    logic [32:0] w_exp, n_exp;
    logic        w_exp_ovf, n_exp_ovf;
    int          w_acc_cyc = 0, n_acc_cyc = 0, w_accepts = 0;
    logic        w_prev_ov = 1'b0, n_prev_ov = 1'b0;

    // Capture the expected result at each accepting edge.
    always @(posedge clk) begin
        cyc++;
        if (rst_n && w_in_valid && w_in_ready) begin
            w_exp     = model(32, w_a, w_b, w_cin, w_sub);
            w_exp_ovf = model_ovf(32, w_a, w_b, w_sub, w_exp[31:0]);
            w_acc_cyc = cyc;
            w_accepts++;
        end
        if (rst_n && n_in_valid && n_in_ready) begin
            n_exp     = model(8, {24'd0, n_a}, {24'd0, n_b}, n_cin, n_sub);
            n_exp_ovf = model_ovf(8, {24'd0, n_a}, {24'd0, n_b}, n_sub, n_exp[31:0]);
            n_acc_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (w_out_valid) begin
                check("w_sum", w_sum, w_exp[31:0]);
                check("w_cout", w_cout, w_exp[32]);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                check("w_ovf", w_ovf, w_exp_ovf);
`endif
                if (!w_prev_ov) check("w_latency", cyc - w_acc_cyc, 4);
            end
            if (w_busy || w_out_valid) check("w_in_ready_blocked", w_in_ready, 0);
            if (n_out_valid) begin
                check("n_sum", n_sum, n_exp[7:0]);
                check("n_cout", n_cout, n_exp[8]);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                check("n_ovf", n_ovf, n_exp_ovf);
`endif
                if (!n_prev_ov) check("n_latency", cyc - n_acc_cyc, 1);
            end
            if (n_busy || n_out_valid) check("n_in_ready_blocked", n_in_ready, 0);
        end
        w_prev_ov = rst_n && w_out_valid;
        n_prev_ov = rst_n && n_out_valid;
    end

    task automatic w_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                        input logic [31:0] xs, input logic xc, input int hold);
        int t;
        w_a = a; w_b = b; w_cin = cin; w_sub = sub; w_in_valid = 1'b1; w_out_ready = 1'b0;
        t = 0;
        while (!w_in_ready && t < 50) begin @(posedge clk); #1; t++; end
        check("w_accept_timeout", (t < 50) ? 1 : 0, 1);
        @(posedge clk); #1;
        w_in_valid = 1'b0; w_a = ~a; w_b = 32'h5A5A5A5A; w_cin = ~cin; w_sub = ~sub;
        t = 0;
        while (!w_out_valid && t < 50) begin @(posedge clk); #1; t++; end
        check("w_done_timeout", (t < 50) ? 1 : 0, 1);
        check("w_sum_lit", w_sum, xs);
        check("w_cout_lit", w_cout, xc);
        repeat (hold) begin @(posedge clk); #1; end
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        check("w_out_valid_drop", w_out_valid, 0);
    endtask

    task automatic n_op(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                        input logic [7:0] xs, input logic xc);
        n_a = a; n_b = b; n_cin = cin; n_sub = sub; n_in_valid = 1'b1; n_out_ready = 1'b0;
        @(posedge clk); #1;
        n_in_valid = 1'b0; n_a = ~a; n_b = ~b;
        check("n_busy_one", n_busy, 1);
        @(posedge clk); #1;
        check("n_out_valid_one", n_out_valid, 1);
        check("n_sum_lit", n_sum, xs);
        check("n_cout_lit", n_cout, xc);
        n_out_ready = 1'b1;
        @(posedge clk); #1;
        n_out_ready = 1'b0;
        check("n_out_valid_drop", n_out_valid, 0);
    endtask

    initial begin
        int acc_before, t;
        #2;
        check("rst_w_in_ready", w_in_ready, 0);
        check("rst_w_out_valid", w_out_valid, 0);
        check("rst_w_sum", w_sum, 0);
        check("rst_w_cout", w_cout, 0);
        check("rst_w_busy", w_busy, 0);
        check("rst_n_in_ready", n_in_ready, 0);
        repeat (2) @(posedge clk);
        #1 check("rst_hold_in_ready", w_in_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_w_in_ready", w_in_ready, 1);
        check("post_rst_n_in_ready", n_in_ready, 1);

        w_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 0);
        w_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 2);
        w_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 0);
        w_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 0);
        w_op(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1);
        w_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 0);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        check("w_ovf_lit_flag_held", w_ovf, 1);
`endif

        // Back-pressure with a new request waiting during DONE.
        w_a = 32'h10; w_b = 32'h20; w_cin = 1'b0; w_sub = 1'b0; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_a = 32'd3; w_b = 32'd4;
        t = 0;
        while (!w_out_valid && t < 50) begin @(posedge clk); #1; t++; end
        check("bp_done_timeout", (t < 50) ? 1 : 0, 1);
        check("bp_sum_lit", w_sum, 32'h30);
        acc_before = w_accepts;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_out_valid_held", w_out_valid, 1);
            check("bp_sum_stable", w_sum, 32'h30);
        end
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        check("bp_no_accept_in_done", w_accepts - acc_before, 0);
        check("bp_in_ready_after_hs", w_in_ready, 1);
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        check("bp_accept_next_cycle", w_accepts - acc_before, 1);
        check("bp_busy", w_busy, 1);
        t = 0;
        while (!w_out_valid && t < 50) begin @(posedge clk); #1; t++; end
        check("bp_second_timeout", (t < 50) ? 1 : 0, 1);
        check("bp_second_sum", w_sum, 32'd7);
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;

        // Abort mid-operation after two chunks.
        w_a = 32'hAAAAAAAA; w_b = 32'h11111111; w_cin = 1'b0; w_sub = 1'b0; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", w_out_valid, 0);
        check("abort_busy", w_busy, 0);
        check("abort_in_ready", w_in_ready, 0);
        check("abort_sum", w_sum, 0);
        check("abort_cout", w_cout, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_idle_ready", w_in_ready, 1);
        check("abort_no_valid", w_out_valid, 0);
        w_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 0);

        n_op(8'h96, 8'hB2, 1'b0, 1'b0, 8'h48, 1'b1);
        n_op(8'h85, 8'h6D, 1'b0, 1'b0, 8'hF2, 1'b0);
        n_op(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder/subtractor, generalising the team's n-bit ripple adder.
- Processes N-bit operands W bits per clock, LSB chunk first, through one W-bit ripple slice with a registered inter-chunk carry.
- Uses valid/ready handshakes on input and output.
- Sits in datapaths where a full-width combinational ripple chain would not meet timing.

Parameters:
N, 32, operand/result width in bits; must be a multiple of W.
W, 8, chunk width processed per cycle; NCHUNK = N/W.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
a  in  N  operand A
b  in  N  operand B
cin  in  1  carry-in (add mode only)
sub  in  1  0: S=A+B+cin; 1: S=A-B (cin ignored)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  N  result
cout  out  1  carry out; in sub mode 1 = no borrow
busy  out  1  high in BUSY

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=0 while rst_n is low, then 1 on the first clk after release.
  - out_valid=0, sum=0, cout=0, busy=0.
  - Internal operand, carry and chunk-counter registers cleared.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - latch a; latch b (or ~b if sub=1).
    - carry = sub ? 1 : cin.
    - chunk index k=0; go to BUSY.
  - BUSY: each cycle adds chunk k of A and B' plus carry through the ripple slice.
    - Writes the W-bit result into sum[k*W +: W] and registers the slice carry-out.
    - k increments each cycle.
    - After chunk NCHUNK-1: cout = final carry; go to DONE.
  - DONE: out_valid=1; sum and cout held stable. On out_ready=1 go to IDLE with out_valid=0 the next cycle.
- Latency:
  - out_valid rises exactly NCHUNK clocks after the accepting edge.
  - With out_ready held high, the next operand is accepted 2 clocks after that.
  - No overlap: in_ready=0 in BUSY and DONE.
- Operand latching: inputs are sampled only at acceptance. Changes to a/b/cin/sub during BUSY have no effect.
- Arithmetic:
  - Modulo 2^N; cout is bit N of the unsigned sum.
  - In sub mode, A-B is computed as A+~B+1.
- sum contents are unspecified while busy=1; consumers must not use them.
- sum and cout are guaranteed only while out_valid=1. They hold their last value until the next operation overwrites them.
- W=N (NCHUNK=1): single BUSY cycle; must work.
- Reset mid-operation: the operation is aborted immediately and all outputs return to reset values. No partial result is ever flagged valid.
- in_valid asserted during BUSY/DONE: ignored (not latched); the source must hold it until accepted.

Optional Feature:
- Macro: SEQ_CHUNK_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0, valid with out_valid.
  - ovf = (A[N-1]==B'[N-1]) && (sum[N-1]!=A[N-1]), i.e. signed two's-complement overflow for add and sub.
- Not defined: port absent; no overflow logic synthesised.

Decomposition:
- Package seq_chunk_adder_pkg:
  - State enum (IDLE, BUSY, DONE).
  - Function computing NCHUNK and the counter width $clog2(NCHUNK) (min 1).
- Sub-module ripple_chunk: W-bit combinational ripple-carry slice (ports a, b, ci -> s, co), built from full-adder cells. Instantiated once.

Test Plan:
- N=32,W=8, add, a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, out_valid exactly 4 clocks after accept.
- N=32,W=8, add, a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1 (carry through all chunks). Same with cin=1, b=0 -> identical result.
- N=32,W=8, sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0; a=7, b=5 -> sum=2, cout=1. With macro: a=0x7FFFFFFF, b=0xFFFFFFFF, sub=1 -> ovf=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> sum/cout stable, in_ready=0, and a new in_valid is not accepted until the cycle after the out_ready handshake.
- Reset mid-BUSY: assert rst_n=0 after 2 chunks -> outputs 0 immediately, state IDLE; next operation 0x12345678+0x11111111 -> 0x23456789, cout=0.
- N=8,W=8: a=0x96, b=0xB2 -> sum=0x48, cout=1, out_valid 1 clock after accept; a=0x85, b=0x6D -> sum=0xF2, cout=0.
